// File: rtl/restorer_if.sv
// ---------------------------------------------------------------------------
// restorer_if
//   Request, memory read-data and restore-strobe signals of the restorer.
//   Addr/ReadEn are not carried here: they sit on a memory bus shared with
//   the backup dispatcher and are tri-stated, so they stay plain ports.
//
//   Start      request a full restore (accepted only while Busy=0)
//   BaseAddr   base address of the backup area, captured with Start
//   RdData     memory read data, valid while RdValid=1
//   RdValid    memory read-data strobe
//   RestoreVal value being written back (registered)
//   RestoreEn  one-hot load strobe, one bit per IC_REG_WRAPPER
//   Busy       restorer is not idle
//   Done       one-cycle pulse at the end of a successful restore
//   Error      one-cycle pulse on a wait timeout
//
//   Handshake: Start has no ready; it is taken on a clock edge where the
//   restorer is idle and dropped otherwise (Busy=1 means "not accepting").
//   RdValid has no ready either; it is taken only on a clock edge where the
//   restorer is waiting for data, and ignored at any other time.
// ---------------------------------------------------------------------------
interface restorer_if #(
    parameter int K = 10,
    parameter int N = 32,
    parameter int M = 32
);
    logic         Start;
    logic [M-1:0] BaseAddr;
    logic [N-1:0] RdData;
    logic         RdValid;
    logic [N-1:0] RestoreVal;
    logic [K-1:0] RestoreEn;
    logic         Busy;
    logic         Done;
    logic         Error;

    modport master (
        output Start, BaseAddr, RdData, RdValid,
        input  RestoreVal, RestoreEn, Busy, Done, Error
    );

    modport slave (
        input  Start, BaseAddr, RdData, RdValid,
        output RestoreVal, RestoreEn, Busy, Done, Error
    );
endinterface

// File: rtl/restorer.sv
// ---------------------------------------------------------------------------
// restorer
//   Read-side counterpart of the backup dispatcher. On Start it reads K saved
//   register values from BaseAddr+0 .. BaseAddr+K-1 and writes each one back
//   into its IC_REG_WRAPPER with a one-hot RestoreEn strobe, then pulses Done.
//
//   Ports
//     Clk       system clock, rising edge
//     Rst       synchronous active-high reset
//     Pwr_off   synchronous active-high; same effect as Rst
//     bus       restorer_if.slave (Start/BaseAddr/RdData/RdValid in,
//               RestoreVal/RestoreEn/Busy/Done/Error out)
//     Addr      memory address, high-Z except while requesting/waiting
//     ReadEn    memory read request, 1 while requesting/waiting, else high-Z
//     StateDbg  current FSM state, for observation only
//
//   Optional feature: define RESTORER_TIMEOUT_EN to abort a read that gets
//   no RdValid within TIMEOUT wait cycles (Error pulse, back to idle).
//   Without it the restorer waits for data indefinitely and Error is 0.
// ---------------------------------------------------------------------------
module restorer #(
    parameter int K       = 10,
    parameter int N       = 32,
    parameter int M       = 32,
    parameter int TIMEOUT = 16
) (
    input  logic         Clk,
    input  logic         Rst,
    input  logic         Pwr_off,
    restorer_if.slave    bus,
    output wire  [M-1:0] Addr,
    output wire          ReadEn,
    output logic [2:0]   StateDbg
);
    localparam int IW = (K > 1) ? $clog2(K) : 1;

    if (K < 1 || TIMEOUT < 1) begin : gBadParams
        $error("restorer: K and TIMEOUT must both be at least 1");
    end

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4,
        S_ERR   = 3'd5
    } state_t;

    state_t        state;
    logic [IW-1:0] idx;
    logic [M-1:0]  baseReg;
    logic          busDrive;   // owns the shared memory bus (REQ and WAIT)

`ifdef RESTORER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] waitCnt;    // WAIT cycles so far without RdValid
`endif

    function automatic logic [K-1:0] oneHot(input logic [IW-1:0] i);
        logic [K-1:0] v;
        v = '0;
        for (int j = 0; j < K; j++) begin
            v[j] = (IW'(j) == i);
        end
        return v;
    endfunction

    // Carry out of the add is dropped on purpose: the backup area may wrap.
    assign Addr     = busDrive ? (baseReg + M'(idx)) : {M{1'bz}};
    assign ReadEn   = busDrive ? 1'b1 : 1'bz;
    assign StateDbg = state;

    always_ff @(posedge Clk) begin
        if (Rst || Pwr_off) begin
            state          <= S_IDLE;
            idx            <= '0;
            baseReg        <= '0;
            busDrive       <= 1'b0;
            bus.RestoreVal <= '0;
            bus.RestoreEn  <= '0;
            bus.Busy       <= 1'b0;
            bus.Done       <= 1'b0;
`ifdef RESTORER_TIMEOUT_EN
            bus.Error      <= 1'b0;
            waitCnt        <= '0;
`endif
        end else begin
            // Strobes and pulses default low; set only on the transition
            // into the state that owns them.
            bus.RestoreEn <= '0;
            bus.Done      <= 1'b0;
`ifdef RESTORER_TIMEOUT_EN
            bus.Error     <= 1'b0;
`endif
            case (state)
                S_IDLE: begin
                    if (bus.Start) begin
                        baseReg  <= bus.BaseAddr;
                        idx      <= '0;
                        busDrive <= 1'b1;
                        bus.Busy <= 1'b1;
                        state    <= S_REQ;
                    end
                end
                S_REQ: begin
                    // RdValid is not looked at here, so memory latency is
                    // at least one cycle.
`ifdef RESTORER_TIMEOUT_EN
                    waitCnt <= '0;
`endif
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (bus.RdValid) begin
                        // Data arriving on the last allowed cycle still wins.
                        bus.RestoreVal <= bus.RdData;
                        bus.RestoreEn  <= oneHot(idx);
                        busDrive       <= 1'b0;
                        state          <= S_WRITE;
`ifdef RESTORER_TIMEOUT_EN
                    end else if (waitCnt == TW'(TIMEOUT - 1)) begin
                        busDrive  <= 1'b0;
                        bus.Error <= 1'b1;
                        state     <= S_ERR;
                    end else begin
                        waitCnt <= waitCnt + 1'b1;
`endif
                    end
                end
                S_WRITE: begin
                    if (idx == IW'(K - 1)) begin
                        bus.Done <= 1'b1;
                        state    <= S_DONE;
                    end else begin
                        idx      <= idx + 1'b1;
                        busDrive <= 1'b1;
                        state    <= S_REQ;
                    end
                end
                S_DONE: begin
                    bus.Busy <= 1'b0;
                    state    <= S_IDLE;
                end
`ifdef RESTORER_TIMEOUT_EN
                S_ERR: begin
                    // Wrappers already restored keep their values.
                    bus.Busy <= 1'b0;
                    idx      <= '0;
                    state    <= S_IDLE;
                end
`endif
                default: begin
                    busDrive <= 1'b0;
                    bus.Busy <= 1'b0;
                    idx      <= '0;
                    state    <= S_IDLE;
                end
            endcase
        end
    end

`ifndef RESTORER_TIMEOUT_EN
    assign bus.Error = 1'b0;
`endif

endmodule

// File: tb/tb_restorer.sv
// ---------------------------------------------------------------------------
// tb_restorer
//   Three restorers (K=4, K=3, K=1) share one set of inputs. Each restore is
//   an "episode": the bench draws a base address, a data seed and a memory
//   latency per register, then derives from those alone the cycle-by-cycle
//   schedule every instance must follow (addresses, strobes, Done/Error,
//   Busy). Memory data is memData(addr) = addr + seed.
//   Cycle 0 of an episode is the cycle in which Start is high.
// ---------------------------------------------------------------------------
module tb_restorer;
    localparam int N   = 32;
    localparam int M   = 32;
    localparam int TMO = 5;

    logic         Clk;
    logic         Rst;
    logic         Pwr_off;
    logic         start;
    logic [M-1:0] baseAddr;
    logic [N-1:0] rdData;
    logic         rdValid;

    int nChecks = 0;
    int nFails  = 0;

    // Episode description shared by driver and monitors.
    int          mode    = 0;   // 0 none, 1 idle checks, 2 episode checks
    int          epCycle = 0;
    int          epLat[4];
    logic [31:0] epBase;
    logic [31:0] epSeed;
    int          epAbort = 0;   // cycle in which reset is raised, 0 = none
    int          epDrop  = -1;  // register whose data never comes, -1 = none

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic checkEq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] memData(input logic [31:0] a);
        return a + epSeed;
    endfunction

    // First cycle of register i's slot minus one: slot i occupies
    // REQ (1) + WAIT (L) + WRITE (1) cycles.
    function automatic int segStart(input int i);
        int s;
        s = 0;
        for (int j = 0; j < i; j++) s += 2 + epLat[j];
        return s;
    endfunction

    // Cycle of the Done pulse, or of the Error pulse when register epDrop
    // times out inside this instance's range.
    function automatic int endCycle(input int k);
        if (epDrop >= 0 && epDrop < k) return segStart(epDrop) + TMO + 2;
        return segStart(k) + 1;
    endfunction

    function automatic void expAt(input int k, input int c, output bit busy, output bit done,
                                  output bit err, output int wr, output bit drv,
                                  output logic [31:0] addr);
        int  e;
        int  s;
        int  hi;
        bit  errCase;
        e       = endCycle(k);
        errCase = (epDrop >= 0 && epDrop < k);
        busy    = (c <= e);
        done    = (c == e) && !errCase;
        err     = (c == e) && errCase;
        wr      = -1;
        drv     = 1'b0;
        addr    = '0;
        for (int i = 0; i < k; i++) begin
            if (!(errCase && i > epDrop)) begin
                s = segStart(i);
                if (!(errCase && i == epDrop) && c == s + 2 + epLat[i]) wr = i;
                hi = s + 1 + ((errCase && i == epDrop) ? TMO : epLat[i]);
                if (c >= s + 1 && c <= hi) begin
                    drv  = 1'b1;
                    addr = epBase + 32'(i);
                end
            end
        end
    endfunction

    for (genvar g = 0; g < 3; g++) begin : gInst
        localparam int KG = (g == 0) ? 4 : ((g == 1) ? 3 : 1);

        restorer_if #(.K(KG), .N(N), .M(M)) bus ();
        wire  [M-1:0] addr;
        wire          readEn;
        logic [2:0]   stateDbg;
        logic [N-1:0] lastVal = '0;
        bit           eBusy, eDone, eErr, eDrv;
        int           eWr;
        logic [31:0]  eAddr;
        logic [63:0]  eEn;

        assign bus.Start    = start;
        assign bus.BaseAddr = baseAddr;
        assign bus.RdData   = rdData;
        assign bus.RdValid  = rdValid;

        restorer #(.K(KG), .N(N), .M(M), .TIMEOUT(TMO)) dut (
            .Clk      (Clk),
            .Rst      (Rst),
            .Pwr_off  (Pwr_off),
            .bus      (bus),
            .Addr     (addr),
            .ReadEn   (readEn),
            .StateDbg (stateDbg)
        );

        always @(negedge Clk) begin
            if (mode == 2 && epCycle >= 1) begin
                if (epAbort > 0 && epCycle == epAbort + 1) begin
                    eBusy = 0; eDone = 0; eErr = 0; eWr = -1; eDrv = 0; eAddr = '0;
                end else begin
                    expAt(KG, epCycle, eBusy, eDone, eErr, eWr, eDrv, eAddr);
                end
                if (eWr >= 0) lastVal = memData(epBase + 32'(eWr));
                eEn = (eWr >= 0) ? (64'd1 << eWr) : 64'd0;
                checkEq($sformatf("k%0d c%0d busy", KG, epCycle), 64'(bus.Busy), 64'(eBusy));
                checkEq($sformatf("k%0d c%0d done", KG, epCycle), 64'(bus.Done), 64'(eDone));
                checkEq($sformatf("k%0d c%0d error", KG, epCycle), 64'(bus.Error), 64'(eErr));
                checkEq($sformatf("k%0d c%0d restoreEn", KG, epCycle), 64'(bus.RestoreEn), eEn);
                checkEq($sformatf("k%0d c%0d restoreVal", KG, epCycle), 64'(bus.RestoreVal), 64'(lastVal));
                if (eDrv) begin
                    checkEq($sformatf("k%0d c%0d addr", KG, epCycle), 64'(addr), 64'(eAddr));
                    checkEq($sformatf("k%0d c%0d readEn", KG, epCycle), 64'(readEn), 64'd1);
                end
            end else if (mode == 1) begin
                checkEq($sformatf("k%0d idle busy", KG), 64'(bus.Busy), 64'd0);
                checkEq($sformatf("k%0d idle done", KG), 64'(bus.Done), 64'd0);
                checkEq($sformatf("k%0d idle error", KG), 64'(bus.Error), 64'd0);
                checkEq($sformatf("k%0d idle restoreEn", KG), 64'(bus.RestoreEn), 64'd0);
                checkEq($sformatf("k%0d idle restoreVal", KG), 64'(bus.RestoreVal), 64'(lastVal));
            end
            if (Rst || Pwr_off) lastVal = '0;
        end
    end

    // Memory side for cycle c: real data on the last WAIT cycle of each slot,
    // stray strobes with junk data only where no instance can be waiting.
    task automatic driveRd(input int c);
        int nv;
        nv      = (epDrop >= 0) ? epDrop : 4;
        rdValid = 1'b0;
        rdData  = $urandom();
        for (int i = 0; i < nv; i++) begin
            if (c == segStart(i) + 1 + epLat[i]) begin
                rdValid = 1'b1;
                rdData  = memData(epBase + 32'(i));
            end
        end
        if (!rdValid) begin
            for (int i = 0; i < 4 && i <= nv; i++) begin
                if ((c == segStart(i) + 1 || (i < nv && c == segStart(i) + 2 + epLat[i]))
                    && $urandom_range(1, 0) == 1) begin
                    rdValid = 1'b1;
                end
            end
        end
    endtask

    task automatic idleCycles(input int n);
        mode  = 1;
        start = 1'b0;
        for (int i = 0; i < n; i++) begin
            rdValid  = 1'($urandom_range(1, 0));
            rdData   = $urandom();
            baseAddr = $urandom();
            @(posedge Clk); #1;
        end
        rdValid = 1'b0;
        mode    = 0;
    endtask

    task automatic runEpisode(input logic [31:0] base, input logic [31:0] seed,
                              input int latLo, input int latHi, input int abortIdx,
                              input int abortKind, input int drop);
        int lastC;
        int t1;
        epBase = base;
        epSeed = seed;
        epDrop = drop;
        for (int i = 0; i < 4; i++) epLat[i] = $urandom_range(latHi, latLo);
        epAbort = (abortIdx >= 0) ? segStart(abortIdx) + 2 : 0;
        lastC   = (epAbort > 0) ? epAbort + 1 : endCycle(4) + 1;
        t1      = endCycle(1);
        epCycle  = 0;
        start    = 1'b1;
        baseAddr = base;
        rdValid  = 1'b0;
        mode     = 2;
        for (int c = 1; c <= lastC; c++) begin
            @(posedge Clk); #1;
            epCycle  = c;
            // Start re-pulsed while every instance is busy (WAIT, and DONE of K=1).
            start    = (c == 2 || c == t1);
            baseAddr = $urandom();
            driveRd(c);
            Rst      = (epAbort > 0 && c == epAbort && abortKind == 0);
            Pwr_off  = (epAbort > 0 && c == epAbort && abortKind == 1);
        end
        @(posedge Clk); #1;
        mode    = 0;
        start   = 1'b0;
        rdValid = 1'b0;
        Rst     = 1'b0;
        Pwr_off = 1'b0;
    endtask

    initial begin
        Rst      = 1'b1;
        Pwr_off  = 1'b0;
        start    = 1'b0;
        baseAddr = '0;
        rdData   = '0;
        rdValid  = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        mode = 1;
        repeat (2) @(posedge Clk);
        #1;
        Rst = 1'b0;
        idleCycles(3);

        // Nominal: base 0x100, latency 2, data 0xA0+i; K=4 Done in cycle 17.
        runEpisode(32'h0000_0100, 32'hFFFF_FFA0, 2, 2, -1, 0, -1);
        idleCycles(3);
        // Address wrap.
        runEpisode(32'hFFFF_FFFE, $urandom(), 1, 4, -1, 0, -1);
        idleCycles(2);
        // Minimum latency: K=1 Done in cycle 4.
        runEpisode($urandom(), $urandom(), 1, 1, -1, 0, -1);
        idleCycles(2);
        // Reset in WAIT for idx 2, then a fresh restore; Rst then Pwr_off.
        runEpisode($urandom(), $urandom(), 1, 3, 2, 0, -1);
        idleCycles(2);
        runEpisode($urandom(), $urandom(), 1, 3, -1, 0, -1);
        idleCycles(2);
        runEpisode($urandom(), $urandom(), 1, 3, 2, 1, -1);
        idleCycles(2);
        runEpisode($urandom(), $urandom(), 1, 3, -1, 0, -1);
        idleCycles(2);
        // Data on exactly the TMO-th wait cycle.
        runEpisode($urandom(), $urandom(), TMO, TMO, -1, 0, -1);
        idleCycles(2);
`ifdef RESTORER_TIMEOUT_EN
        // idx 1 never answered: Error after TMO wait cycles, then recover.
        runEpisode($urandom(), $urandom(), 1, 3, -1, 0, 1);
        idleCycles(3);
        runEpisode($urandom(), $urandom(), 1, 3, -1, 0, -1);
        idleCycles(2);
`else
        // Long latency is simply waited out.
        runEpisode($urandom(), $urandom(), 9, 12, -1, 0, -1);
        idleCycles(2);
`endif
        for (int r = 0; r < 6; r++) begin
            runEpisode($urandom(), $urandom(), 1, TMO, -1, 0, -1);
            idleCycles($urandom_range(4, 1));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end
endmodule
